// File: rtl/tank_pkg.sv
// Shared types, screen limits and terrain profile for the tank game.
package tank_pkg;

    localparam int unsigned COORD_W      = 10;
    localparam int unsigned POS_W        = 11;
    localparam int unsigned SCREEN_X_MAX = 639;
    localparam int unsigned SCREEN_Y_MAX = 479;

    localparam logic [1:0] DIR_LEFT  = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FLIGHT  = 2'd1,
        EXPLODE = 2'd2
    } shell_state_t;

    // Terrain height: 607*x^2/1562500 - 71*x/500 + 267, each division truncating.
    // The quadratic product is kept wide enough for any 10-bit x.
    function automatic logic [COORD_W-1:0] ground_y(input logic [COORD_W-1:0] x);
        logic [29:0]        quad;
        logic [16:0]        lin;
        logic [COORD_W-1:0] quad_q;
        logic [COORD_W-1:0] lin_q;
        quad   = 30'(x) * 30'(x) * 30'd607;
        lin    = 17'(x) * 17'd71;
        quad_q = COORD_W'(quad / 30'd1562500);
        lin_q  = COORD_W'(lin / 17'd500);
        return COORD_W'(10'd267 + quad_q - lin_q);
    endfunction

endpackage

// File: rtl/shell_collide.sv
// Combinational enemy-box and terrain collision tests for the current shell position.
module shell_collide
    import tank_pkg::*;
(
    input  logic signed [POS_W-1:0]   shell_x,
    input  logic signed [POS_W-1:0]   shell_y,
    input  logic        [COORD_W-1:0] shell_s,
    input  logic        [COORD_W-1:0] enemy_x,
    input  logic        [COORD_W-1:0] enemy_y,
    input  logic        [COORD_W-1:0] enemy_s,
    output logic                      hit_enemy,
    output logic                      hit_ground
);

    localparam int unsigned DW = POS_W + 1;

    logic signed [DW-1:0]      dx;
    logic signed [DW-1:0]      dy;
    logic        [DW-1:0]      adx;
    logic        [DW-1:0]      ady;
    logic        [DW-1:0]      reach;
    logic        [COORD_W-1:0] gy;

    always_comb begin
        dx    = DW'(shell_x) - DW'(enemy_x);
        dy    = DW'(shell_y) - DW'(enemy_y);
        adx   = dx[DW-1] ? DW'(-dx) : DW'(dx);
        ady   = dy[DW-1] ? DW'(-dy) : DW'(dy);
        reach = DW'(shell_s) + DW'(enemy_s);
        hit_enemy = (adx <= reach) && (ady <= reach);

        // Shell x never goes negative in flight, so its low bits index the terrain directly.
        gy         = ground_y(shell_x[COORD_W-1:0]);
        hit_ground = (DW'(shell_y) >= $signed({2'b00, gy}));
    end

endmodule

// File: rtl/tank_shell.sv
// Single-shell projectile engine: launch on a fire edge, ballistic flight per frame,
// then enemy hit / terrain impact explosion or silent off-screen exit.
module tank_shell
    import tank_pkg::*;
#(
    parameter int unsigned SHELL_SIZE     = 2,
    parameter int unsigned SHELL_VX       = 2,
    parameter int unsigned AIM_MAX        = 15,
    parameter int unsigned GRAV_DIV       = 4,
    parameter int unsigned VY_MAX         = 15,
    parameter int unsigned EXPLODE_FRAMES = 16
) (
    input  logic               frame_clk,
    input  logic               Reset_n,
    input  logic               shoot,
    input  logic [COORD_W-1:0] TankX,
    input  logic [COORD_W-1:0] TankY,
    input  logic [COORD_W-1:0] TankS,
    input  logic [1:0]         Direction,
    input  logic [COORD_W-1:0] y_component,
    input  logic [COORD_W-1:0] EnemyX,
    input  logic [COORD_W-1:0] EnemyY,
    input  logic [COORD_W-1:0] EnemyS,
    output logic [COORD_W-1:0] ShellX,
    output logic [COORD_W-1:0] ShellY,
    output logic [COORD_W-1:0] ShellS,
    output logic               shell_active,
    output logic               exploding,
    output logic               hit
);

    localparam int unsigned STEP_W = POS_W + 1;
    localparam int unsigned GRAV_W = (GRAV_DIV > 1) ? $clog2(GRAV_DIV) : 1;
    localparam int unsigned EXP_W  = (EXPLODE_FRAMES > 1) ? $clog2(EXPLODE_FRAMES) : 1;

    localparam logic        [GRAV_W-1:0] GRAV_LAST = GRAV_W'(GRAV_DIV - 1);
    localparam logic        [EXP_W-1:0]  EXP_LAST  = EXP_W'(EXPLODE_FRAMES - 1);
    localparam logic signed [POS_W-1:0]  VX_MAG    = POS_W'(SHELL_VX);
    localparam logic signed [POS_W-1:0]  AIM_LIM   = POS_W'(AIM_MAX);
    localparam logic signed [POS_W-1:0]  VY_LIM    = POS_W'(VY_MAX);
    localparam logic signed [POS_W-1:0]  VY_ONE    = POS_W'(1);
    localparam logic signed [STEP_W-1:0] X_LIM     = STEP_W'(SCREEN_X_MAX);
    localparam logic signed [STEP_W-1:0] Y_LIM     = STEP_W'(SCREEN_Y_MAX);

    shell_state_t              state, state_nxt;
    logic signed [POS_W-1:0]   shell_x, shell_x_nxt;
    logic signed [POS_W-1:0]   shell_y, shell_y_nxt;
    logic signed [POS_W-1:0]   vx, vx_nxt;
    logic signed [POS_W-1:0]   vy, vy_nxt;
    logic        [GRAV_W-1:0]  grav_cnt, grav_cnt_nxt;
    logic        [EXP_W-1:0]   expl_cnt, expl_cnt_nxt;
    logic                      shoot_d;
    logic                      hit_nxt;

    logic                      fire;
    logic signed [POS_W-1:0]   aim_ext;
    logic signed [POS_W-1:0]   aim_clamp;
    logic signed [STEP_W-1:0]  step_x;
    logic signed [STEP_W-1:0]  step_y;
    logic                      hit_enemy;
    logic                      hit_ground;
    logic        [COORD_W-1:0] shell_s;

    assign shell_s = COORD_W'(SHELL_SIZE);
    assign ShellS  = shell_s;
    assign ShellX  = shell_x[COORD_W-1:0];
    assign ShellY  = shell_y[COORD_W-1:0];

    shell_collide u_collide (
        .shell_x    (shell_x),
        .shell_y    (shell_y),
        .shell_s    (shell_s),
        .enemy_x    (EnemyX),
        .enemy_y    (EnemyY),
        .enemy_s    (EnemyS),
        .hit_enemy  (hit_enemy),
        .hit_ground (hit_ground)
    );

    // State, datapath and status flags; status flags track the state being entered.
    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state        <= IDLE;
            shell_x      <= '0;
            shell_y      <= '0;
            vx           <= '0;
            vy           <= '0;
            grav_cnt     <= '0;
            expl_cnt     <= '0;
            shoot_d      <= 1'b0;
            shell_active <= 1'b0;
            exploding    <= 1'b0;
            hit          <= 1'b0;
        end else begin
            state        <= state_nxt;
            shell_x      <= shell_x_nxt;
            shell_y      <= shell_y_nxt;
            vx           <= vx_nxt;
            vy           <= vy_nxt;
            grav_cnt     <= grav_cnt_nxt;
            expl_cnt     <= expl_cnt_nxt;
            shoot_d      <= shoot;
            shell_active <= (state_nxt == FLIGHT);
            exploding    <= (state_nxt == EXPLODE);
            hit          <= hit_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        shell_x_nxt  = shell_x;
        shell_y_nxt  = shell_y;
        vx_nxt       = vx;
        vy_nxt       = vy;
        grav_cnt_nxt = grav_cnt;
        expl_cnt_nxt = expl_cnt;
        hit_nxt      = 1'b0;

        fire    = shoot && !shoot_d;
        aim_ext = POS_W'($signed(y_component));
        if (aim_ext > AIM_LIM) begin
            aim_clamp = AIM_LIM;
        end else if (aim_ext < -AIM_LIM) begin
            aim_clamp = -AIM_LIM;
        end else begin
            aim_clamp = aim_ext;
        end
        step_x = STEP_W'(shell_x) + STEP_W'(vx);
        step_y = STEP_W'(shell_y) + STEP_W'(vy);

        unique case (state)
            IDLE: begin
                if (fire) begin
                    state_nxt    = FLIGHT;
                    shell_x_nxt  = POS_W'(TankX);
                    shell_y_nxt  = POS_W'(TankY) - POS_W'(TankS);
                    vx_nxt       = (Direction == DIR_LEFT) ? -VX_MAG : VX_MAG;
                    vy_nxt       = -aim_clamp;
                    grav_cnt_nxt = '0;
                end
            end
            FLIGHT: begin
                // Priority: enemy hit, terrain, off-screen, then move.
                if (hit_enemy) begin
                    state_nxt    = EXPLODE;
                    expl_cnt_nxt = '0;
                    hit_nxt      = 1'b1;
                end else if (hit_ground) begin
                    state_nxt    = EXPLODE;
                    expl_cnt_nxt = '0;
                end else if (step_x < 0 || step_x > X_LIM || step_y > Y_LIM) begin
                    state_nxt = IDLE;
                end else begin
                    shell_x_nxt = POS_W'(step_x);
                    shell_y_nxt = POS_W'(step_y);
                    if (grav_cnt == GRAV_LAST) begin
                        grav_cnt_nxt = '0;
                        vy_nxt       = (vy >= VY_LIM) ? VY_LIM : vy + VY_ONE;
                    end else begin
                        grav_cnt_nxt = grav_cnt + GRAV_W'(1);
                    end
                end
            end
            EXPLODE: begin
                if (expl_cnt == EXP_LAST) begin
                    state_nxt = IDLE;
                end else begin
                    expl_cnt_nxt = expl_cnt + EXP_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_tank_shell.sv
// Directed bench for tank_shell: launch, flight, gravity, hit, terrain, off-screen and reset.
module tb_tank_shell;

    logic       frame_clk = 1'b0;
    logic       Reset_n;
    logic       shoot;
    logic [9:0] TankX, TankY, TankS;
    logic [1:0] Direction;
    logic [9:0] y_component;
    logic [9:0] EnemyX, EnemyY, EnemyS;
    logic [9:0] ShellX, ShellY, ShellS;
    logic       shell_active, exploding, hit;

    logic [22:0] obs;
    int          checks = 0;
    int          errors = 0;

    assign obs = {ShellX, ShellY, shell_active, exploding, hit};

    always #5 frame_clk = ~frame_clk;

    tank_shell #(
        .SHELL_SIZE     (2),
        .SHELL_VX       (2),
        .AIM_MAX        (15),
        .GRAV_DIV       (4),
        .VY_MAX         (15),
        .EXPLODE_FRAMES (16)
    ) dut (
        .frame_clk    (frame_clk),
        .Reset_n      (Reset_n),
        .shoot        (shoot),
        .TankX        (TankX),
        .TankY        (TankY),
        .TankS        (TankS),
        .Direction    (Direction),
        .y_component  (y_component),
        .EnemyX       (EnemyX),
        .EnemyY       (EnemyY),
        .EnemyS       (EnemyS),
        .ShellX       (ShellX),
        .ShellY       (ShellY),
        .ShellS       (ShellS),
        .shell_active (shell_active),
        .exploding    (exploding),
        .hit          (hit)
    );

    function automatic string obs_str();
        return $sformatf("x=%0d y=%0d act=%0b expl=%0b hit=%0b",
                         ShellX, ShellY, shell_active, exploding, hit);
    endfunction

    task automatic tick;
        @(posedge frame_clk);
        #1;
    endtask

    task automatic set_tank(input int x, input int y, input int s, input int dir, input int aim);
        TankX       = 10'(x);
        TankY       = 10'(y);
        TankS       = 10'(s);
        Direction   = 2'(dir);
        y_component = 10'(aim);
    endtask

    task automatic set_enemy(input int x, input int y, input int s);
        EnemyX = 10'(x);
        EnemyY = 10'(y);
        EnemyS = 10'(s);
    endtask

    task automatic apply_reset;
        shoot = 1'b0;
        #2 Reset_n = 1'b0;
        @(negedge frame_clk);
        Reset_n = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        Reset_n = 1'b0;
        shoot   = 1'b1;
        set_tank(140, 210, 4, 1, 0);
        set_enemy(600, 400, 4);
        repeat (2) tick();
        #2;
        checks++;
        if (obs !== 23'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %s, want all zero", obs_str());
        end
        checks++;
        if (ShellS !== 10'd2) begin
            errors++;
            $display("FAIL shell_size: got %0d, want 2", ShellS);
        end
        // shoot held through release fires on the first frame
        @(negedge frame_clk);
        Reset_n = 1'b1;
        tick();
        checks++;
        if (obs !== {10'd140, 10'd206, 3'b100}) begin
            errors++;
            $display("FAIL reset_release_fire: got %s, want x=140 y=206 act=1 expl=0 hit=0", obs_str());
        end
        #2 Reset_n = 1'b0;
        #1;
        checks++;
        if (obs !== 23'd0) begin
            errors++;
            $display("FAIL reset_async_clear: got %s, want all zero", obs_str());
        end
        shoot = 1'b0;
        @(negedge frame_clk);
        Reset_n = 1'b1;
        tick();
    endtask

    task automatic test_fire_right_flat;
        set_tank(140, 210, 4, 1, 0);
        set_enemy(600, 400, 4);
        shoot = 1'b1;
        tick();
        checks++;
        if (obs !== {10'd140, 10'd206, 3'b100}) begin
            errors++;
            $display("FAIL flat_launch: got %s, want x=140 y=206 act=1", obs_str());
        end
        tick();
        checks++;
        if (obs !== {10'd142, 10'd206, 3'b100}) begin
            errors++;
            $display("FAIL flat_move1: got %s, want x=142 y=206 act=1", obs_str());
        end
        tick();
        checks++;
        if (obs !== {10'd144, 10'd206, 3'b100}) begin
            errors++;
            $display("FAIL flat_move2: got %s, want x=144 y=206 act=1", obs_str());
        end
        tick();
        checks++;
        if (obs !== {10'd146, 10'd206, 3'b100}) begin
            errors++;
            $display("FAIL flat_move3: got %s, want x=146 y=206 act=1", obs_str());
        end
        tick();
        checks++;
        if (obs !== {10'd148, 10'd206, 3'b100}) begin
            errors++;
            $display("FAIL flat_move4: got %s, want x=148 y=206 act=1", obs_str());
        end
        // vy became 1 on the 4th move, visible on the 5th
        tick();
        checks++;
        if (obs !== {10'd150, 10'd207, 3'b100}) begin
            errors++;
            $display("FAIL flat_gravity: got %s, want x=150 y=207 act=1", obs_str());
        end
    endtask

    task automatic test_held_shoot;
        int n;
        shoot = 1'b0;
        tick();
        checks++;
        if (obs !== {10'd152, 10'd208, 3'b100}) begin
            errors++;
            $display("FAIL held_move6: got %s, want x=152 y=208 act=1", obs_str());
        end
        shoot = 1'b1;
        tick();
        checks++;
        if (obs !== {10'd154, 10'd209, 3'b100}) begin
            errors++;
            $display("FAIL held_refire_ignored: got %s, want x=154 y=209 act=1", obs_str());
        end
        n = 0;
        while (!exploding && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 16) begin
            errors++;
            $display("FAIL held_ground_frames: got %0d frames to explode, want 16", n);
        end
        checks++;
        if (obs !== {10'd184, 10'd256, 3'b010}) begin
            errors++;
            $display("FAIL held_ground_impact: got %s, want x=184 y=256 expl=1 hit=0", obs_str());
        end
        n = 0;
        while (exploding && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 16) begin
            errors++;
            $display("FAIL held_explode_len: got %0d frames, want 16", n);
        end
        repeat (3) tick();
        checks++;
        if (obs !== {10'd184, 10'd256, 3'b000}) begin
            errors++;
            $display("FAIL held_no_relaunch: got %s, want x=184 y=256 idle", obs_str());
        end
        shoot = 1'b0;
        tick();
        shoot = 1'b1;
        tick();
        checks++;
        if (obs !== {10'd140, 10'd206, 3'b100}) begin
            errors++;
            $display("FAIL held_fresh_launch: got %s, want x=140 y=206 act=1", obs_str());
        end
        // tank inputs after launch must not steer the shell
        set_tank(300, 100, 9, 0, 10);
        tick();
        checks++;
        if (obs !== {10'd142, 10'd206, 3'b100}) begin
            errors++;
            $display("FAIL launch_sampled_once: got %s, want x=142 y=206 act=1", obs_str());
        end
        apply_reset();
    endtask

    task automatic test_enemy_hit;
        set_tank(140, 210, 4, 1, 0);
        set_enemy(150, 206, 4);
        shoot = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if (obs !== {10'd144, 10'd206, 3'b100}) begin
            errors++;
            $display("FAIL hit_approach: got %s, want x=144 y=206 act=1", obs_str());
        end
        tick();
        checks++;
        if (obs !== {10'd144, 10'd206, 3'b011}) begin
            errors++;
            $display("FAIL hit_pulse: got %s, want x=144 y=206 expl=1 hit=1", obs_str());
        end
        tick();
        checks++;
        if (obs !== {10'd144, 10'd206, 3'b010}) begin
            errors++;
            $display("FAIL hit_single_pulse: got %s, want x=144 y=206 expl=1 hit=0", obs_str());
        end
        repeat (14) tick();
        checks++;
        if (obs !== {10'd144, 10'd206, 3'b010}) begin
            errors++;
            $display("FAIL hit_explode_last: got %s, want expl=1 on 16th frame", obs_str());
        end
        tick();
        checks++;
        if (obs !== {10'd144, 10'd206, 3'b000}) begin
            errors++;
            $display("FAIL hit_explode_end: got %s, want idle at x=144 y=206", obs_str());
        end
        shoot = 1'b0;
        tick();
    endtask

    task automatic test_lob_ground;
        set_tank(100, 250, 4, 1, 15);
        set_enemy(600, 400, 4);
        shoot = 1'b1;
        tick();
        checks++;
        if (obs !== {10'd100, 10'd246, 3'b100}) begin
            errors++;
            $display("FAIL lob_launch: got %s, want x=100 y=246 act=1", obs_str());
        end
        for (int n = 1; n <= 127; n++) begin
            tick();
            if (n == 1) begin
                checks++;
                if (obs !== {10'd102, 10'd231, 3'b100}) begin
                    errors++;
                    $display("FAIL lob_first_move: got %s, want x=102 y=231", obs_str());
                end
            end
            if (n == 60) begin
                checks++;
                if (obs !== {10'd220, 10'd790, 3'b100}) begin
                    errors++;
                    $display("FAIL lob_apex_negative_y: got %s, want x=220 y=790(-234) act=1", obs_str());
                end
            end
            if (n == 124) begin
                checks++;
                if (obs !== {10'd348, 10'd246, 3'b100}) begin
                    errors++;
                    $display("FAIL lob_descent: got %s, want x=348 y=246 act=1", obs_str());
                end
            end
            if (n == 126) begin
                checks++;
                if (obs !== {10'd352, 10'd276, 3'b100}) begin
                    errors++;
                    $display("FAIL lob_vy_clamp: got %s, want x=352 y=276 act=1", obs_str());
                end
            end
            if (n == 127) begin
                checks++;
                if (obs !== {10'd352, 10'd276, 3'b010}) begin
                    errors++;
                    $display("FAIL lob_ground_impact: got %s, want x=352 y=276 expl=1 hit=0", obs_str());
                end
            end
        end
        apply_reset();
    endtask

    task automatic test_offscreen_left;
        // downward aim of -50 clamps to vy=+15
        set_tank(3, 210, 4, 0, 974);
        set_enemy(600, 400, 4);
        shoot = 1'b1;
        tick();
        checks++;
        if (obs !== {10'd3, 10'd206, 3'b100}) begin
            errors++;
            $display("FAIL off_launch: got %s, want x=3 y=206 act=1", obs_str());
        end
        tick();
        checks++;
        if (obs !== {10'd1, 10'd221, 3'b100}) begin
            errors++;
            $display("FAIL off_move1: got %s, want x=1 y=221 act=1", obs_str());
        end
        tick();
        checks++;
        if (obs !== {10'd1, 10'd221, 3'b000}) begin
            errors++;
            $display("FAIL off_exit: got %s, want x=1 y=221 idle no explode", obs_str());
        end
        tick();
        checks++;
        if (obs !== {10'd1, 10'd221, 3'b000}) begin
            errors++;
            $display("FAIL off_stays_idle: got %s, want x=1 y=221 idle", obs_str());
        end
        shoot = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_flight;
        set_tank(140, 210, 4, 1, 0);
        set_enemy(600, 400, 4);
        shoot = 1'b1;
        tick();
        tick();
        checks++;
        if (obs !== {10'd142, 10'd206, 3'b100}) begin
            errors++;
            $display("FAIL abort_pre: got %s, want x=142 y=206 act=1", obs_str());
        end
        #2 Reset_n = 1'b0;
        #1;
        checks++;
        if (obs !== 23'd0) begin
            errors++;
            $display("FAIL abort_async: got %s, want all zero", obs_str());
        end
        tick();
        shoot = 1'b0;
        @(negedge frame_clk);
        Reset_n = 1'b1;
        tick();
        checks++;
        if (obs !== 23'd0) begin
            errors++;
            $display("FAIL abort_stays_idle: got %s, want all zero", obs_str());
        end
    endtask

    initial begin
        Reset_n = 1'b0;
        shoot   = 1'b0;
        set_tank(0, 0, 0, 0, 0);
        set_enemy(0, 0, 0);
        test_reset();
        test_fire_right_flat();
        test_held_shoot();
        test_enemy_hit();
        test_lob_ground();
        test_offscreen_left();
        test_reset_mid_flight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tank_shell.md
# tank_shell

Projectile engine for one tank. It consumes the fire pulse, position, facing and aim produced by that tank's controller, then flies a single shell under gravity, one step per frame. It detects an enemy-tank hit, a terrain impact or an off-screen exit, and reports the shell position and state to the sprite renderer and the scoring logic.

## Interface
- SHELL_SIZE, 2: shell half-size in pixels, driven on ShellS.
- SHELL_VX, 2: horizontal speed in pixels per frame.
- AIM_MAX, 15: clamp applied to |aim| to form the initial vertical speed.
- GRAV_DIV, 4: number of flight frames per +1 increment of vy.
- VY_MAX, 15: terminal downward vy.
- EXPLODE_FRAMES, 16: explosion duration in frames.
- frame_clk, in, 1: the only clock, one rising edge per video frame.
- Reset_n, in, 1: asynchronous, active-low reset.
- shoot, in, 1: fire request from the tank controller; may be held as a level.
- TankX, TankY, TankS, in, 10 each: firing tank centre and half-size.
- Direction, in, 2: 0 = left, 1 = right; any other value is treated as right.
- y_component, in, 10: aim as two's complement; positive means upward.
- EnemyX, EnemyY, EnemyS, in, 10 each: target tank centre and half-size.
- ShellX, ShellY, out, 10 each: shell centre.
- ShellS, out, 10: constant SHELL_SIZE.
- shell_active, out, 1: high in FLIGHT.
- exploding, out, 1: high in EXPLODE.
- hit, out, 1: one-frame pulse on an enemy hit.

## Operation
- States and transitions:
  - IDLE: on a fire edge, go to FLIGHT.
  - FLIGHT: on a hit or a ground impact, go to EXPLODE; on an off-screen exit, go to IDLE.
  - EXPLODE: after EXPLODE_FRAMES frames, go to IDLE.
- Fire edge: shoot=1 and shoot_d=0, where shoot_d is shoot registered once per frame.
  - Edges outside IDLE are discarded; nothing is queued.
- Launch from IDLE:
  - ShellX = TankX.
  - ShellY = TankY - TankS.
  - vx = -SHELL_VX if Direction == 0, else +SHELL_VX.
  - vy = -clamp(y_component, ±AIM_MAX).
  - Gravity counter cleared to 0.
- Internal position and velocity are 11-bit signed, so negative coordinates can be detected.
- Each FLIGHT frame evaluates the current registered position, in this priority order:
  1. Enemy hit: |ShellX-EnemyX| <= ShellS+EnemyS and |ShellY-EnemyY| <= ShellS+EnemyS. Go to EXPLODE, pulse hit, freeze the position.
  2. Ground: ShellY >= ground_y(ShellX). Go to EXPLODE, no hit pulse, freeze the position.
  3. Off-screen: next x < 0, next x > 639, or next y > 479. Go to IDLE, position unchanged. A shell with y < 0 keeps flying.
  4. Otherwise: x += vx and y += vy.
     - Gravity counter += 1.
     - When the counter reaches GRAV_DIV-1, vy = min(vy+1, VY_MAX) and the counter resets to 0.
- ground_y(x) = 607·x²/1562500 − 71·x/500 + 267.
  - Each division truncates separately.
  - The 607·x² product needs 28 bits unsigned.
- EXPLODE counter runs from 0 to EXPLODE_FRAMES-1, then the block returns to IDLE.
- ShellX and ShellY hold their last value in IDLE.

## Timing
- All registers update on posedge frame_clk. Reset_n low clears them immediately, without waiting for a clock edge.
- Reset values:
  - state = IDLE.
  - ShellX = ShellY = 0.
  - shell_active = exploding = hit = 0.
  - shoot_d = 0, so shoot held high through reset release fires on the first frame.
- Reset mid-flight or mid-explosion aborts the shell; no hit pulse is emitted.
- Latency:
  - Fire edge seen at frame k: shell_active = 1 and the launch position is visible after edge k.
  - First movement appears after edge k+1.
- hit is high for exactly the one frame that follows the EXPLODE entry edge.
- TankX, TankY, Direction and y_component are sampled only at launch; later changes do not affect an airborne shell.

## Structure
- Package tank_pkg:
  - shell_state_t enum: IDLE, FLIGHT, EXPLODE.
  - Screen bounds 639 and 479.
  - Direction encodings.
  - Function ground_y(), shared with the terrain renderer.
- Sub-module shell_collide, combinational: takes the shell position and size plus the enemy position and size, and outputs hit_enemy and hit_ground.

## Test plan
- Reset: assert Reset_n=0 mid-frame -> all outputs are 0 with no clock edge; state is IDLE.
- Fire right, flat: TankX=140, TankY=210, TankS=4, Direction=1, y=0, shoot 0→1.
  - After the next edge: (140,206), shell_active=1.
  - Following frames: (142,206), (144,206), (146,206).
  - vy becomes 1 after the 4th flight frame.
- Held shoot: shoot stays high through the whole flight -> no relaunch. A second 0→1 during FLIGHT is ignored. After return to IDLE, a fresh edge launches.
- Enemy hit: enemy at (150,206), EnemyS=4, fired as above.
  - hit pulses once when ShellX reaches 144.
  - exploding stays high for 16 frames, then IDLE.
- Lob into ground: aim=+15, Direction=1 -> vy starts at -15 and the shell rises, then falls. EXPLODE occurs at the first frame where ShellY >= ground_y(ShellX); hit=0.
- Off-screen left: TankX=3, Direction=0 -> after the launch frame the shell goes to IDLE with no explode and no hit. Then assert Reset_n mid-FLIGHT on a separate launch -> the shell is cleared immediately.
